// File: rtl/midway8080_video_pipeline.sv
// Midway 8080 video pipeline: raster coordinates in, column-major video RAM
// reads out, registered RGB with an animated rainbow band overlay.
// Optional feature macro: MIDWAY_COCKTAIL_FLIP_EN (adds the cocktail flip input).
module midway8080_video_pipeline #(
  parameter int MEM_LATENCY = 1,
  parameter int COLOR_DEPTH = 10,
  parameter int ACTIVE_W    = 224,
  parameter int ACTIVE_H    = 256,
  parameter int BAND_WIDTH  = 28,
  parameter int NUM_BANDS   = 7,
  parameter int COLOR_Y_MIN = 17,
  parameter int COLOR_Y_MAX = 169,
  parameter int SCROLL_DIV  = 4,
  parameter int SCROLL_STEP = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [9:0]                 in_x,
  input  logic [8:0]                 in_y,
  input  logic                       frame_start,
  input  logic                       scroll_en,
  input  logic                       color_en,
`ifdef MIDWAY_COCKTAIL_FLIP_EN
  input  logic                       flip,
`endif
  output logic                       mem_rd_en,
  output logic [7:0]                 mem_addr_x,
  output logic [4:0]                 mem_addr_y,
  input  logic [7:0]                 mem_data,
  output logic                       out_valid,
  output logic [3*COLOR_DEPTH-1:0]   rgb_out,
  output logic [9:0]                 out_x,
  output logic [8:0]                 out_y
);

  localparam int SPAN = NUM_BANDS * BAND_WIDTH;
  localparam int OW   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int FCW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int LS   = MEM_LATENCY - 1;
  localparam int CD   = COLOR_DEPTH;

  localparam logic [9:0]     AW    = 10'(ACTIVE_W);
  localparam logic [9:0]     AH    = 10'(ACTIVE_H);
  localparam logic [8:0]     AH9   = 9'(ACTIVE_H);
  localparam logic [8:0]     YMIN  = 9'(COLOR_Y_MIN);
  localparam logic [8:0]     YMAX  = 9'(COLOR_Y_MAX);
  localparam logic [FCW-1:0] CLAST = FCW'(SCROLL_DIV - 1);
  localparam logic [9:0]     ORG10 = 10'h190 >> (10 - COLOR_DEPTH);
  localparam logic [CD-1:0]  ORG   = ORG10[CD-1:0];
  localparam logic [CD-1:0]  FULL  = '1;
  localparam logic [CD-1:0]  ZERO  = '0;

  function automatic logic [3*CD-1:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = {FULL, ZERO, ZERO};
      3'd1:    palette = {FULL, ORG,  ZERO};
      3'd2:    palette = {FULL, FULL, ZERO};
      3'd3:    palette = {ZERO, FULL, ZERO};
      3'd4:    palette = {ZERO, FULL, FULL};
      3'd5:    palette = {ZERO, ZERO, FULL};
      3'd6:    palette = {FULL, ZERO, FULL};
      default: palette = {FULL, FULL, FULL};
    endcase
  endfunction

  // ---------------- request stage (combinational) ----------------
  logic       req_area;
  logic       req_color;
  logic [9:0] ax;
  logic [8:0] ay;
  logic [2:0] req_bit;

  assign req_area = (in_x < AW) && ({1'b0, in_y} < AH);

`ifdef MIDWAY_COCKTAIL_FLIP_EN
  logic flip_q;

  // Flip is only taken at frame boundaries so a frame never mixes orientations.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          flip_q <= 1'b0;
    else if (frame_start) flip_q <= flip;
  end

  // Mirror in-range coordinates; out-of-range ones are blanked anyway.
  always_comb begin
    ax = in_x;
    ay = in_y;
    if (flip_q && req_area) begin
      ax = AW - 10'd1 - in_x;
      ay = AH9 - 9'd1 - in_y;
    end
  end
`else
  assign ax = in_x;
  assign ay = in_y;
`endif

  assign req_color  = color_en && (ax < AW) && (ay >= YMIN) && (ay <= YMAX);
  assign req_bit    = 3'd7 - ay[2:0];
  assign mem_rd_en  = in_valid;
  assign mem_addr_x = ax[7:0];
  assign mem_addr_y = 5'd31 - ay[7:3];

  // ---------------- scroll state ----------------
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [OW-1:0]  pend_q, pend_d;
  logic [OW-1:0]  act_q, act_d;

  // Frame counter and offsets; act takes the pre-update pending value so
  // a new offset shows one frame late and never mid-frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pend_d      = pend_q;
    act_d       = act_q;
    if (frame_start) begin
      act_d = pend_q;
      if (scroll_en) begin
        if (frame_cnt_q == CLAST) begin
          frame_cnt_d = '0;
          pend_d      = OW'((int'(pend_q) + SCROLL_STEP) % SPAN);
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // Scroll state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
      pend_q      <= '0;
      act_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

  // ---------------- delay line ----------------
  logic [MEM_LATENCY-1:0] vld_q, area_q, color_q;
  logic [9:0]             x_q   [MEM_LATENCY];
  logic [9:0]             cx_q  [MEM_LATENCY];
  logic [8:0]             y_q   [MEM_LATENCY];
  logic [2:0]             bit_q [MEM_LATENCY];
  logic [OW-1:0]          off_q [MEM_LATENCY];

  // Carry request attributes alongside the RAM access so they line up with mem_data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      area_q  <= '0;
      color_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        x_q[i]   <= '0;
        cx_q[i]  <= '0;
        y_q[i]   <= '0;
        bit_q[i] <= '0;
        off_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= in_valid;
      area_q[0]  <= req_area;
      color_q[0] <= req_color;
      x_q[0]     <= in_x;
      cx_q[0]    <= ax;
      y_q[0]     <= in_y;
      bit_q[0]   <= req_bit;
      off_q[0]   <= act_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        area_q[i]  <= area_q[i-1];
        color_q[i] <= color_q[i-1];
        x_q[i]     <= x_q[i-1];
        cx_q[i]    <= cx_q[i-1];
        y_q[i]     <= y_q[i-1];
        bit_q[i]   <= bit_q[i-1];
        off_q[i]   <= off_q[i-1];
      end
    end
  end

  // ---------------- colour stage ----------------
  logic              pix;
  logic [2:0]        bucket;
  logic [3*CD-1:0]   rgb_d;
  int                band_pos;

  // Pick the output colour from the RAM bit and the band under this column.
  always_comb begin
    band_pos = (int'(cx_q[LS]) + int'(off_q[LS])) % SPAN;
    bucket   = 3'(band_pos / BAND_WIDTH);
    pix      = area_q[LS] & mem_data[bit_q[LS]];
    rgb_d    = '0;
    if (pix) begin
      if (color_q[LS]) rgb_d = palette(bucket);
      else             rgb_d = '1;
    end
  end

  logic            out_valid_q;
  logic [3*CD-1:0] rgb_q;
  logic [9:0]      out_x_q;
  logic [8:0]      out_y_q;

  // Output register; colour and coordinates hold across idle cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= vld_q[LS];
      if (vld_q[LS]) begin
        rgb_q   <= rgb_d;
        out_x_q <= x_q[LS];
        out_y_q <= y_q[LS];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign rgb_out   = rgb_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_midway8080_video_pipeline.sv
// Bench for midway8080_video_pipeline: two instances (RAM latency 2 and 4)
// share stimulus; a frame-buffer model plus scoreboard predicts every output.
module tb_midway8080_video_pipeline;

  localparam int LA = 2;
  localparam int LB = 4;

  typedef struct {
    int          due;
    logic [29:0] rgb;
    logic [9:0]  x;
    logic [8:0]  y;
  } exp_t;

  typedef struct {
    int          x;
    int          y;
    logic        ce;
    logic [7:0]  data;
    logic [29:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_x = '0;
  logic [8:0]  in_y = '0;
  logic        frame_start = 1'b0;
  logic        scroll_en = 1'b0;
  logic        color_en = 1'b0;

  logic        rd_a, rd_b, ov_a, ov_b;
  logic [7:0]  ax_a, ax_b, md_a, md_b;
  logic [4:0]  ay_a, ay_b;
  logic [29:0] rgb_a, rgb_b;
  logic [9:0]  ox_a, ox_b;
  logic [8:0]  oy_a, oy_b;

  midway8080_video_pipeline #(.MEM_LATENCY(LA)) u_dut_a (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .frame_start(frame_start), .scroll_en(scroll_en), .color_en(color_en),
    .mem_rd_en(rd_a), .mem_addr_x(ax_a), .mem_addr_y(ay_a), .mem_data(md_a),
    .out_valid(ov_a), .rgb_out(rgb_a), .out_x(ox_a), .out_y(oy_a));

  midway8080_video_pipeline #(.MEM_LATENCY(LB)) u_dut_b (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .frame_start(frame_start), .scroll_en(scroll_en), .color_en(color_en),
    .mem_rd_en(rd_b), .mem_addr_x(ax_b), .mem_addr_y(ay_b), .mem_data(md_b),
    .out_valid(ov_b), .rgb_out(rgb_b), .out_x(ox_b), .out_y(oy_b));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Video RAM model: byte index = column*32 + row, returned L cycles after the read.
  logic [7:0]  mem [8192];
  logic [12:0] hist_a [LA];
  logic [12:0] hist_b [LB];
  always @(posedge clock) begin
    hist_a[0] <= {ax_a, ay_a};
    hist_b[0] <= {ax_b, ay_b};
    for (int i = 1; i < LA; i++) hist_a[i] <= hist_a[i-1];
    for (int i = 1; i < LB; i++) hist_b[i] <= hist_b[i-1];
  end
  assign md_a = mem[hist_a[LA-1]];
  assign md_b = mem[hist_b[LB-1]];

  logic [29:0] pal [8] = '{30'h3FF00000, 30'h3FF64000, 30'h3FFFFC00, 30'h000FFC00,
                           30'h000FFFFF, 30'h000003FF, 30'h3FF003FF, 30'h3FFFFFFF};

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [29:0] last_rgb [2] = '{30'h0, 30'h0};
  logic [9:0]  last_x   [2] = '{10'h0, 10'h0};
  logic [8:0]  last_y   [2] = '{9'h0, 9'h0};
  int   vcnt_b = 0, run_b = 0, max_run_b = 0;

  int m_cnt = 0, m_pend = 0, m_act = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int mem_idx(input int x, input int y);
    return (x % 256) * 32 + (31 - (y / 8) % 32);
  endfunction

  function automatic logic [29:0] model_rgb(input int x, input int y, input logic ce, input int off);
    logic [7:0] d;
    logic       p;
    d = mem[mem_idx(x, y)];
    p = (x < 224 && y < 256) ? d[7 - (y % 8)] : 1'b0;
    if (!p) return 30'h0;
    if (ce && x < 224 && y >= 17 && y <= 169) return pal[((x + off) % 196) / 28];
    return 30'h3FFFFFFF;
  endfunction

  task automatic check_out(input int id, input logic ov, input logic [29:0] rgb,
                           input logic [9:0] ox, input logic [8:0] oy);
    exp_t e;
    logic have;
    string s;
    have = 1'b0;
    s = (id == 0) ? "a" : "b";
    if (id == 0) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin e = qa.pop_front(); have = 1'b1; end
    end else begin
      if (qb.size() > 0 && qb[0].due == cyc) begin e = qb.pop_front(); have = 1'b1; end
    end
    if (have) begin
      chk({"out_valid_", s}, 32'(ov), 32'd1);
      chk({"rgb_", s}, 32'(rgb), 32'(e.rgb));
      chk({"out_x_", s}, 32'(ox), 32'(e.x));
      chk({"out_y_", s}, 32'(oy), 32'(e.y));
      last_rgb[id] = e.rgb;
      last_x[id]   = e.x;
      last_y[id]   = e.y;
    end else begin
      chk({"idle_valid_", s}, 32'(ov), 32'd0);
      chk({"hold_rgb_", s}, 32'(rgb), 32'(last_rgb[id]));
      chk({"hold_xy_", s}, {13'(ox), 19'(oy)}, {13'(last_x[id]), 19'(last_y[id])});
    end
  endtask

  // Compare both pipelines every cycle against the scoreboard.
  always @(negedge clock) begin
    check_out(0, ov_a, rgb_a, ox_a, oy_a);
    check_out(1, ov_b, rgb_b, ox_b, oy_b);
    if (ov_b) begin
      vcnt_b++;
      run_b++;
      if (run_b > max_run_b) max_run_b = run_b;
    end else begin
      run_b = 0;
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic v, input int x, input int y, input logic fs,
                       input logic se, input logic ce, input logic use_c,
                       input logic [29:0] c);
    exp_t e;
    in_valid = v; in_x = 10'(x); in_y = 9'(y);
    frame_start = fs; scroll_en = se; color_en = ce;
    #1;
    chk("mem_rd_en", {30'd0, rd_a, rd_b}, {30'd0, v, v});
    chk("mem_addr_x", {16'd0, ax_a, ax_b}, {16'd0, 8'(x % 256), 8'(x % 256)});
    chk("mem_addr_y", {22'd0, ay_a, ay_b}, {22'd0, 5'(31 - (y / 8) % 32), 5'(31 - (y / 8) % 32)});
    if (v) begin
      e.rgb = use_c ? c : model_rgb(x, y, ce, m_act);
      e.x = 10'(x);
      e.y = 9'(y);
      e.due = cyc + LA + 1; qa.push_back(e);
      e.due = cyc + LB + 1; qb.push_back(e);
    end
    if (fs) begin
      m_act = m_pend;
      if (se) begin
        m_cnt++;
        if (m_cnt == 4) begin m_cnt = 0; m_pend = (m_pend + 1) % 196; end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0);
  endtask

  task automatic pulse_frame();
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0);
    idle(2);
  endtask

  task automatic req_const(input int x, input int y, input logic ce, input logic [29:0] c);
    drive(1'b1, x, y, 1'b0, 1'b1, ce, 1'b1, c);
    idle(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[18];
  int   base;

  initial begin
    tbl[0]  = '{0,   0,   1'b0, 8'h80, 30'h3FFFFFFF};
    tbl[1]  = '{30,  20,  1'b1, 8'h08, 30'h3FF64000};
    tbl[2]  = '{224, 20,  1'b1, 8'hFF, 30'h00000000};
    tbl[3]  = '{5,   20,  1'b1, 8'h08, 30'h3FF00000};
    tbl[4]  = '{5,   16,  1'b1, 8'h80, 30'h3FFFFFFF};
    tbl[5]  = '{5,   17,  1'b1, 8'h40, 30'h3FF00000};
    tbl[6]  = '{6,   169, 1'b1, 8'h40, 30'h3FF00000};
    tbl[7]  = '{7,   170, 1'b1, 8'h20, 30'h3FFFFFFF};
    tbl[8]  = '{195, 20,  1'b1, 8'h08, 30'h3FF003FF};
    tbl[9]  = '{223, 100, 1'b1, 8'h08, 30'h3FF00000};
    tbl[10] = '{10,  255, 1'b0, 8'h01, 30'h3FFFFFFF};
    tbl[11] = '{10,  256, 1'b0, 8'hFF, 30'h00000000};
    tbl[12] = '{10,  20,  1'b1, 8'hF7, 30'h00000000};
    tbl[13] = '{56,  50,  1'b1, 8'h20, 30'h3FFFFC00};
    tbl[14] = '{84,  50,  1'b1, 8'h20, 30'h000FFC00};
    tbl[15] = '{112, 50,  1'b1, 8'h20, 30'h000FFFFF};
    tbl[16] = '{140, 50,  1'b1, 8'h20, 30'h000003FF};
    tbl[17] = '{168, 50,  1'b1, 8'h20, 30'h3FF003FF};

    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    idle(2);

    // Directed single pixels, spaced so nothing overlaps in flight.
    for (int i = 0; i < 18; i++) begin
      mem[mem_idx(tbl[i].x, tbl[i].y)] = tbl[i].data;
      drive(1'b1, tbl[i].x, tbl[i].y, 1'b0, 1'b0, tbl[i].ce, 1'b1, tbl[i].exp);
      idle(6);
    end

    // Scroll: offset 1 after the 5th frame pulse, 2 after the 9th.
    mem[mem_idx(195, 20)] = 8'h08;
    mem[mem_idx(194, 20)] = 8'h08;
    for (int p = 1; p <= 8; p++) begin
      pulse_frame();
      if (p == 4) req_const(195, 20, 1'b1, 30'h3FF003FF);
      if (p == 5) req_const(195, 20, 1'b1, 30'h3FF00000);
    end
    req_const(194, 20, 1'b1, 30'h3FF003FF);
    drive(1'b1, 194, 20, 1'b1, 1'b1, 1'b1, 1'b1, 30'h3FF003FF);
    idle(6);
    req_const(194, 20, 1'b1, 30'h3FF00000);

    // 300 back-to-back requests, no gaps on either pipeline.
    base = vcnt_b;
    for (int i = 0; i < 300; i++)
      drive(1'b1, $urandom_range(0, 223), $urandom_range(0, 255), 1'b0, 1'b1,
            1'($urandom_range(0, 1)), 1'b0, 30'h0);
    idle(8);
    chk("burst_count", 32'(vcnt_b - base), 32'd300);
    chk("burst_run", 32'(max_run_b >= 300), 32'd1);

    // Randomized traffic against the model, including frame pulses.
    for (int i = 0; i < 2500; i++)
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 300), $urandom_range(0, 300),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'b0, 30'h0);
    idle(8);

    // Reset with three requests in flight; everything must be discarded.
    for (int i = 0; i < 3; i++) drive(1'b1, 10 + i, 20, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0);
    resetn = 1'b0;
    qa.delete();
    qb.delete();
    last_rgb = '{30'h0, 30'h0};
    last_x = '{10'h0, 10'h0};
    last_y = '{9'h0, 9'h0};
    m_cnt = 0; m_pend = 0; m_act = 0;
    idle(3);
    resetn = 1'b1;
    idle(8);

    mem[mem_idx(195, 20)] = 8'h08;
    req_const(195, 20, 1'b1, 30'h3FF003FF);
    for (int p = 1; p <= 5; p++) pulse_frame();
    req_const(195, 20, 1'b1, 30'h3FF00000);

    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 260), $urandom_range(0, 260),
            1'($urandom_range(0, 15) == 0), 1'b1, 1'b1, 1'b0, 30'h0);
    idle(8);

    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
